time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Real-time clock core: divides clk down to a 1 Hz tick and keeps hours/minutes/seconds in 24 h format.
//  Consumes the one-cycle hours/minutes edit pulses routed to the clock path by the mode selector.
//  Produces current_time, which feeds the mode selector's display mux and the alarm logic.
// PARAMETERS
//  CLK_FREQ   100_000_000  clk cycles per second; prescaler terminal count is CLK_FREQ-1 (min 2)
// PORTS
//  clk           in   1   clock; single clock domain
//  reset         in   1   synchronous, active-high reset
//  edit_btns     in   2   edit pulses, one clk wide: [1]=hours +1, [0]=minutes +1
//  current_time  out  17  {hours[16:12] 0-23, minutes[11:6] 0-59, seconds[5:0] 0-59}, unsigned binary
//  sec_tick      out  1   one-cycle pulse, asserted in the cycle the seconds field advances
//  alarm_time    in   17  (ALARM_MATCH_EN only) alarm setpoint, same format as current_time
//  alarm_match   out  1   (ALARM_MATCH_EN only) one-cycle pulse on alarm hit
// BEHAVIOUR
//  - Reset (sync, high): prescaler=0, current_time=17'd0 (00:00:00), sec_tick=0, alarm_match=0.
//    Reset wins over every other input in the same cycle; asserting it mid-count drops any pending tick.
//  - Prescaler counts 0..CLK_FREQ-1 then wraps to 0; the wrap cycle is the internal tick.
//  - All outputs are registered: current_time and sec_tick update on the clk edge following the tick,
//    so sec_tick and the new seconds value are visible in the same cycle.
//  - Tick: seconds +1; 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0.
//    23:59:59 + tick -> 00:00:00 in one cycle.
//  - edit_btns[0]: minutes +1 modulo 60; no carry into hours; seconds and prescaler untouched.
//  - edit_btns[1]: hours +1 modulo 24; minutes, seconds and prescaler untouched.
//  - Both edit bits high in one cycle: both fields increment independently.
//  - Edit coinciding with a tick: seconds still advance. For the edited field, the edit wins and any
//    carry arriving from the lower field is discarded, so the field increments by exactly 1.
//    Example: 10:59:59 + tick + minutes edit -> 10:00:00 (minute wrap from the edit, no hour carry).
//    Carries into fields that are not being edited propagate normally.
//  - Edit pulses held high for N cycles increment N times; pulse shaping is the upstream's job.
//  - No field ever holds an out-of-range value: hours>23 and minutes/seconds>59 are unreachable.
// CONFIGURATION
//  `define ALARM_MATCH_EN
//    defined: adds the alarm_time input and the alarm_match output. alarm_match is a registered one-cycle
//      pulse in the cycle after current_time becomes equal to alarm_time on {hours,minutes}, gated by
//      sec_tick with seconds==0. It fires once per day per setpoint; edits never raise it.
//    undefined: both ports are absent, no compare logic is built, all other behaviour is identical.
// STRUCTURE
//  - clock_pkg: typedef struct packed {logic [4:0] hours; logic [5:0] minutes; logic [5:0] seconds;} time_t;
//    constants HOURS_MAX=23, MINUTES_MAX=59, SECONDS_MAX=59. The package is shared with the mode selector,
//    the alarm and the display blocks.
//  - Sub-module mod_counter #(MAX, W): inputs inc, clr; outputs value, carry (inc && value==MAX).
//    Instantiated three times (seconds, minutes, hours); the edit precedence lives in time_keeper.
//  - The prescaler is a local counter of width $clog2(CLK_FREQ).
// TESTING (bench uses CLK_FREQ=4)
//  1 reset, then 12 clk -> sec_tick pulses on every 4th cycle, current_time = 00:00:03, no extra pulses.
//  2 preload to 23:59:58 via edits+ticks, 8 clk -> 23:59:59 then 00:00:00, sec_tick present on the wrap.
//  3 edit_btns=2'b01 x60 pulses from 00:00:xx -> minutes back to 0, hours unchanged; 2'b10 x24 -> hours 0.
//  4 at 10:59:59, drive edit_btns[0] in the tick cycle -> 10:00:00; edit_btns=2'b11 off-tick -> 11:01:00.
//  5 assert reset for 1 cycle mid-prescale at 05:30:20 -> next cycle 00:00:00, first tick 4 cycles later.
//  6 (ALARM_MATCH_EN) alarm_time=00:01:00, run from reset -> exactly one alarm_match after 00:01:00 appears;
//    editing minutes onto 00:01 -> no alarm_match.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types and field limits.
// Used by the time keeper, mode selector, alarm and display blocks.
package clock_pkg;

    localparam int unsigned HOURS_W   = 5;
    localparam int unsigned MINUTES_W = 6;
    localparam int unsigned SECONDS_W = 6;
    localparam int unsigned TIME_W    = HOURS_W + MINUTES_W + SECONDS_W;

    localparam int unsigned HOURS_MAX   = 23;
    localparam int unsigned MINUTES_MAX = 59;
    localparam int unsigned SECONDS_MAX = 59;

    typedef struct packed {
        logic [HOURS_W-1:0]   hours;
        logic [MINUTES_W-1:0] minutes;
        logic [SECONDS_W-1:0] seconds;
    } time_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter used for each time field.
// Ports:
//   clk    in   clock
//   clr    in   synchronous clear to 0 (wins over inc)
//   inc    in   advance by one, wrapping MAX -> 0
//   value  out  registered count, always 0..MAX
//   carry  out  combinational: inc while value == MAX (wrap about to happen)
module mod_counter #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    assign at_max = (value_q == W'(MAX));
    assign carry  = inc && at_max;
    assign value  = value_q;

    // Next count: clear, wrap at MAX, or hold.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = at_max ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

endmodule

// File: rtl/time_keeper.sv
// Real-time clock core: prescales clk to a 1 Hz tick and keeps 24 h hh:mm:ss.
// Ports:
//   clk           in   clock, single domain
//   reset         in   synchronous active-high reset
//   edit_btns     in   one-cycle edit pulses: [1] hours +1, [0] minutes +1
//   alarm_time    in   alarm setpoint (ALARM_MATCH_EN builds only)
//   alarm_match   out  one-cycle alarm pulse (ALARM_MATCH_EN builds only)
//   current_time  out  {hours, minutes, seconds}, registered
//   sec_tick      out  one-cycle pulse aligned with each seconds advance
// Optional feature macro: ALARM_MATCH_EN adds the alarm compare.
module time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        edit_btns,
`ifdef ALARM_MATCH_EN
    input  logic [TIME_W-1:0] alarm_time,
    output logic              alarm_match,
`endif
    output logic [TIME_W-1:0] current_time,
    output logic              sec_tick
);

    localparam int unsigned PS_W = $clog2(CLK_FREQ);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ - 1);

    logic [PS_W-1:0] prescale_q;
    logic [PS_W-1:0] prescale_d;
    logic            sec_tick_q;
    logic            sec_tick_d;
    logic            tick_c;

    logic [SECONDS_W-1:0] seconds;
    logic [MINUTES_W-1:0] minutes;
    logic [HOURS_W-1:0]   hours;
    logic                 sec_carry;
    logic                 min_carry;
    logic                 min_inc;
    logic                 hr_inc;
    logic                 unused_hours_carry;
    time_t                now;

    assign tick_c = (prescale_q == PS_LAST);

    // Prescaler and tick register; reset discards a tick due in the same cycle.
    always_comb begin
        prescale_d = tick_c ? '0 : prescale_q + PS_W'(1);
        sec_tick_d = tick_c;
        if (reset) begin
            prescale_d = '0;
            sec_tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        prescale_q <= prescale_d;
        sec_tick_q <= sec_tick_d;
    end

    // A field being edited takes exactly +1; a carry from below into it is dropped,
    // and the edit's own wrap never carries upward.
    assign min_inc = edit_btns[0] | sec_carry;
    assign hr_inc  = edit_btns[1] | (min_carry & ~edit_btns[0]);

    mod_counter #(.MAX(SECONDS_MAX), .W(SECONDS_W)) u_seconds (
        .clk   (clk),
        .clr   (reset),
        .inc   (tick_c),
        .value (seconds),
        .carry (sec_carry)
    );

    mod_counter #(.MAX(MINUTES_MAX), .W(MINUTES_W)) u_minutes (
        .clk   (clk),
        .clr   (reset),
        .inc   (min_inc),
        .value (minutes),
        .carry (min_carry)
    );

    // Midnight wrap carry has no consumer.
    mod_counter #(.MAX(HOURS_MAX), .W(HOURS_W)) u_hours (
        .clk   (clk),
        .clr   (reset),
        .inc   (hr_inc),
        .value (hours),
        .carry (unused_hours_carry)
    );

    always_comb begin
        now         = '0;
        now.hours   = hours;
        now.minutes = minutes;
        now.seconds = seconds;
    end

    assign current_time = now;
    assign sec_tick     = sec_tick_q;

`ifdef ALARM_MATCH_EN
    time_t                alarm_set;
    logic                 edit_seen_q;
    logic                 edit_seen_d;
    logic                 alarm_match_q;
    logic                 alarm_match_d;
    logic [SECONDS_W-1:0] unused_alarm_seconds;

    assign alarm_set            = alarm_time;
    assign unused_alarm_seconds = alarm_set.seconds;

    // Fire only when a tick, not an edit, rolled the clock onto hh:mm:00.
    always_comb begin
        edit_seen_d   = |edit_btns;
        alarm_match_d = sec_tick_q && !edit_seen_q
                        && (now.seconds == '0)
                        && (now.hours   == alarm_set.hours)
                        && (now.minutes == alarm_set.minutes);
        if (reset) begin
            edit_seen_d   = 1'b0;
            alarm_match_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        edit_seen_q   <= edit_seen_d;
        alarm_match_q <= alarm_match_d;
    end

    assign alarm_match = alarm_match_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with CLK_FREQ = 4.
module tb_time_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  edit_btns = 2'b00;
    logic [16:0] current_time;
    logic        sec_tick;
`ifdef ALARM_MATCH_EN
    logic [16:0] alarm_time;
    logic        alarm_match;
    int          hits;
    int          first_at;
`endif

    int checks = 0;
    int errors = 0;

    time_keeper #(.CLK_FREQ(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .edit_btns    (edit_btns),
`ifdef ALARM_MATCH_EN
        .alarm_time   (alarm_time),
        .alarm_match  (alarm_match),
`endif
        .current_time (current_time),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        edit_btns = 2'b00;
        step(1);
        reset     = 1'b0;
    endtask

    initial begin
`ifdef ALARM_MATCH_EN
        alarm_time = mk(12, 34, 0);
`endif
        // 1: reset state and tick cadence
        do_reset();
        check("reset_time", 32'(current_time), 32'(mk(0, 0, 0)));
        check("reset_tick", 32'(sec_tick), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("cadence_tick", 32'(sec_tick), 32'((k % 4) == 0));
        end
        check("cadence_time", 32'(current_time), 32'(mk(0, 0, 3)));

        // 2: preload to 23:59:58 and wrap through midnight
        do_reset();
        edit_btns = 2'b11;
        step(23);
        edit_btns = 2'b01;
        step(36);
        edit_btns = 2'b00;
        check("preload_edits", 32'(current_time), 32'(mk(23, 59, 14)));
        step(173);
        check("preload_time", 32'(current_time), 32'(mk(23, 59, 58)));
        step(4);
        check("pre_wrap_time", 32'(current_time), 32'(mk(23, 59, 59)));
        check("pre_wrap_tick", 32'(sec_tick), 32'd1);
        step(4);
        check("midnight_time", 32'(current_time), 32'(mk(0, 0, 0)));
        check("midnight_tick", 32'(sec_tick), 32'd1);

        // 3: edits wrap without carry
        edit_btns = 2'b01;
        step(60);
        check("min_edit_wrap", 32'(current_time), 32'(mk(0, 0, 15)));
        edit_btns = 2'b10;
        step(24);
        edit_btns = 2'b00;
        check("hr_edit_wrap", 32'(current_time), 32'(mk(0, 0, 21)));

        // 4: edit coinciding with a carry-producing tick, then dual edit
        do_reset();
        edit_btns = 2'b10;
        step(10);
        edit_btns = 2'b01;
        step(59);
        edit_btns = 2'b00;
        step(167);
        check("at_10_59_59", 32'(current_time), 32'(mk(10, 59, 59)));
        step(3);
        edit_btns = 2'b01;
        step(1);
        edit_btns = 2'b00;
        check("edit_on_tick", 32'(current_time), 32'(mk(10, 0, 0)));
        check("edit_on_tick_pulse", 32'(sec_tick), 32'd1);
        edit_btns = 2'b11;
        step(1);
        edit_btns = 2'b00;
        check("dual_edit", 32'(current_time), 32'(mk(11, 1, 0)));

        // 5: reset mid-prescale
        do_reset();
        edit_btns = 2'b10;
        step(5);
        edit_btns = 2'b01;
        step(30);
        edit_btns = 2'b00;
        step(45);
        check("at_05_30_20", 32'(current_time), 32'(mk(5, 30, 20)));
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_reset_time", 32'(current_time), 32'(mk(0, 0, 0)));
        check("mid_reset_tick", 32'(sec_tick), 32'd0);
        step(3);
        check("post_reset_quiet", 32'(sec_tick), 32'd0);
        step(1);
        check("post_reset_first_tick", 32'(sec_tick), 32'd1);
        check("post_reset_time", 32'(current_time), 32'(mk(0, 0, 1)));

`ifdef ALARM_MATCH_EN
        // 6: alarm fires once on tick-driven arrival, never on edit
        alarm_time = mk(0, 1, 0);
        do_reset();
        hits     = 0;
        first_at = 0;
        for (int k = 1; k <= 260; k++) begin
            step(1);
            if (alarm_match) begin
                hits++;
                first_at = k;
            end
        end
        check("alarm_hits", 32'(hits), 32'd1);
        check("alarm_cycle", 32'(first_at), 32'd241);
        do_reset();
        edit_btns = 2'b01;
        step(1);
        edit_btns = 2'b00;
        check("alarm_edit_time", 32'(current_time), 32'(mk(0, 1, 0)));
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            if (alarm_match) hits++;
            step(1);
        end
        check("alarm_edit_none", 32'(hits), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
